// File: rtl/mc_controller.sv
// Multi-cycle MIPS control unit: walks each instruction through FETCH..WB and
// drives datapath enables/muxes from the current state and the held IR.
//
// state  | meaning
// FETCH  | IM read, PC+4, IR/PC load on last wait cycle
// DECODE | opcode dispatch, branch target into ALUOut
// EXEC_R | R-type ALU operation
// EXEC_I | ori / lui ALU operation
// ADDR   | lw/sw effective address
// MEM_RD | DM read wait
// MEM_WR | DM write, strobe on last wait cycle
// WB_MEM | load write-back
// WB_ALU | ALU write-back
// BRANCH | beq compare and conditional PC load
// JUMP   | j / jal / jr
module mc_controller #(
  parameter int MEM_LAT = 1,
  parameter int ST_W    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr,
  input  logic            zero,
  output logic            pc_write,
  output logic            ir_write,
  output logic            reg_write,
  output logic            mem_write,
  output logic [1:0]      reg_dst,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [2:0]      alu_op,
  output logic [1:0]      ext_op,
  output logic [1:0]      mem_to_reg,
  output logic [1:0]      pc_src,
  output logic [ST_W-1:0] state,
  output logic            illegal
);

  localparam logic [ST_W-1:0] S_FETCH  = ST_W'(0);
  localparam logic [ST_W-1:0] S_DECODE = ST_W'(1);
  localparam logic [ST_W-1:0] S_EXEC_R = ST_W'(2);
  localparam logic [ST_W-1:0] S_EXEC_I = ST_W'(3);
  localparam logic [ST_W-1:0] S_ADDR   = ST_W'(4);
  localparam logic [ST_W-1:0] S_MEM_RD = ST_W'(5);
  localparam logic [ST_W-1:0] S_MEM_WR = ST_W'(6);
  localparam logic [ST_W-1:0] S_WB_MEM = ST_W'(7);
  localparam logic [ST_W-1:0] S_WB_ALU = ST_W'(8);
  localparam logic [ST_W-1:0] S_BRANCH = ST_W'(9);
  localparam logic [ST_W-1:0] S_JUMP   = ST_W'(10);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_next;
  logic [3:0]      r_wait;
  logic            w_wait_done;

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic       w_rtype, w_ralu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;
  logic       w_unused;

  assign w_op     = instr[31:26];
  assign w_fn     = instr[5:0];
  assign w_unused = ^instr[25:6];

  assign w_rtype = (w_op == 6'h00);
  assign w_ralu  = w_rtype && (w_fn == 6'h21 || w_fn == 6'h23 || w_fn == 6'h2A || w_fn == 6'h00);
  assign w_jr    = w_rtype && (w_fn == 6'h08);
  assign w_ori   = (w_op == 6'h0D);
  assign w_lui   = (w_op == 6'h0F);
  assign w_lw    = (w_op == 6'h23);
  assign w_sw    = (w_op == 6'h2B);
  assign w_beq   = (w_op == 6'h04);
  assign w_j     = (w_op == 6'h02);
  assign w_jal   = (w_op == 6'h03);

  assign w_wait_done = (r_wait == LAT_M1);

  // The wait counter only advances while a wait state holds; any exit clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_wait  <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_wait <= 4'd0;
      else                   r_wait <= r_wait + 4'd1;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = w_wait_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_ralu)                  w_next = S_EXEC_R;
        else if (w_jr || w_j || w_jal) w_next = S_JUMP;
        else if (w_ori || w_lui)     w_next = S_EXEC_I;
        else if (w_lw || w_sw)       w_next = S_ADDR;
        else if (w_beq)              w_next = S_BRANCH;
        else                         w_next = S_FETCH;
      end
      S_EXEC_R: w_next = S_WB_ALU;
      S_EXEC_I: w_next = S_WB_ALU;
      S_ADDR:   w_next = w_lw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: w_next = w_wait_done ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR: w_next = w_wait_done ? S_FETCH : S_MEM_WR;
      default:  w_next = S_FETCH;
    endcase
  end

  assign state = r_state;

  // Reset masks every control output so nothing is written in a reset cycle.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    reg_dst    = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 3'd0;
    ext_op     = 2'd0;
    mem_to_reg = 2'd0;
    pc_src     = 2'd0;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        alu_src_b = 2'd1;
        ir_write  = w_wait_done;
        pc_write  = w_wait_done;
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        ext_op    = 2'd1;
        illegal   = !(w_ralu || w_jr || w_ori || w_lui || w_lw || w_sw || w_beq || w_j || w_jal);
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        case (w_fn)
          6'h21:   alu_op = 3'd0;
          6'h23:   alu_op = 3'd1;
          6'h2A:   alu_op = 3'd3;
          default: alu_op = 3'd4;
        endcase
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = w_lui ? 3'd5 : 3'd2;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        reg_dst   = w_rtype ? 2'd1 : 2'd0;
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        ext_op    = 2'd1;
      end
      S_MEM_WR: mem_write = w_wait_done;
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 3'd1;
        pc_src    = 2'd1;
        pc_write  = zero;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = w_jr ? 2'd3 : 2'd2;
        if (w_jal) begin
          reg_write  = 1'b1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
        end
      end
      default: ;
    endcase
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      reg_dst    = 2'd0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_op     = 3'd0;
      ext_op     = 2'd0;
      mem_to_reg = 2'd0;
      pc_src     = 2'd0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: three instances at MEM_LAT 1/2/3 run directed and
// random instruction streams; a reference model queues per-cycle expected outputs.
module tb_mc_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] reg_dst;
    logic       a_src;
    logic [1:0] b_src;
    logic [2:0] alu;
    logic [1:0] ext;
    logic [1:0] m2r;
    logic [1:0] pcs;
    logic       ill;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [3];
  logic [31:0] ins [3];
  logic        z   [3];
  logic        pcw [3], irw [3], rgw [3], mw [3], asa [3], ill [3];
  logic [1:0]  rdst [3], asb [3], ext [3], m2r [3], pcs [3];
  logic [2:0]  aop [3];
  logic [3:0]  st  [3];

  obs_t q0[$], q1[$], q2[$], scr[$];
  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mc_controller #(.MEM_LAT(g + 1), .ST_W(4)) u_dut (
      .clk(clk), .reset(rst[g]), .instr(ins[g]), .zero(z[g]),
      .pc_write(pcw[g]), .ir_write(irw[g]), .reg_write(rgw[g]), .mem_write(mw[g]),
      .reg_dst(rdst[g]), .alu_src_a(asa[g]), .alu_src_b(asb[g]), .alu_op(aop[g]),
      .ext_op(ext[g]), .mem_to_reg(m2r[g]), .pc_src(pcs[g]), .state(st[g]),
      .illegal(ill[g])
    );
  end

  function automatic obs_t get_obs(int k);
    obs_t o;
    o.st = st[k];        o.pc_write = pcw[k];  o.ir_write = irw[k];
    o.reg_write = rgw[k]; o.mem_write = mw[k]; o.reg_dst = rdst[k];
    o.a_src = asa[k];    o.b_src = asb[k];     o.alu = aop[k];
    o.ext = ext[k];      o.m2r = m2r[k];       o.pcs = pcs[k];
    o.ill = ill[k];
    return o;
  endfunction

  function automatic void push(int k, obs_t o);
    case (k)
      0:       q0.push_back(o);
      1:       q1.push_back(o);
      default: q2.push_back(o);
    endcase
  endfunction

  // Reference: per-instruction list of cycles, built from the instruction class.
  function automatic int build(logic [31:0] w, logic zz, int lat);
    obs_t o;
    logic [5:0] opc = w[31:26];
    logic [5:0] fn  = w[5:0];
    bit ralu = (opc == 6'h00) && (fn inside {6'h21, 6'h23, 6'h2A, 6'h00});
    bit jr   = (opc == 6'h00) && (fn == 6'h08);
    bit ori  = (opc == 6'h0D);
    bit lui  = (opc == 6'h0F);
    bit lw   = (opc == 6'h23);
    bit sw   = (opc == 6'h2B);
    bit beq  = (opc == 6'h04);
    bit jmp  = (opc == 6'h02);
    bit jal  = (opc == 6'h03);
    bit ok   = ralu | jr | ori | lui | lw | sw | beq | jmp | jal;
    scr.delete();
    for (int c = 0; c < lat; c++) begin
      o = '0; o.b_src = 2'd1;
      o.pc_write = (c == lat - 1); o.ir_write = (c == lat - 1);
      scr.push_back(o);
    end
    o = '0; o.st = 4'd1; o.b_src = 2'd3; o.ext = 2'd1; o.ill = !ok;
    scr.push_back(o);
    if (ralu || ori || lui) begin
      o = '0; o.st = ralu ? 4'd2 : 4'd3; o.a_src = 1'b1;
      if (ralu) o.alu = (fn == 6'h21) ? 3'd0 : (fn == 6'h23) ? 3'd1 : (fn == 6'h2A) ? 3'd3 : 3'd4;
      else begin o.b_src = 2'd2; o.alu = ori ? 3'd2 : 3'd5; end
      scr.push_back(o);
      o = '0; o.st = 4'd8; o.reg_write = 1'b1; o.reg_dst = ralu ? 2'd1 : 2'd0;
      scr.push_back(o);
    end else if (lw || sw) begin
      o = '0; o.st = 4'd4; o.a_src = 1'b1; o.b_src = 2'd2; o.ext = 2'd1;
      scr.push_back(o);
      for (int c = 0; c < lat; c++) begin
        o = '0; o.st = lw ? 4'd5 : 4'd6; o.mem_write = sw && (c == lat - 1);
        scr.push_back(o);
      end
      if (lw) begin
        o = '0; o.st = 4'd7; o.reg_write = 1'b1; o.m2r = 2'd1;
        scr.push_back(o);
      end
    end else if (beq) begin
      o = '0; o.st = 4'd9; o.a_src = 1'b1; o.alu = 3'd1; o.pcs = 2'd1; o.pc_write = zz;
      scr.push_back(o);
    end else if (jr || jmp || jal) begin
      o = '0; o.st = 4'd10; o.pc_write = 1'b1; o.pcs = jr ? 2'd3 : 2'd2;
      if (jal) begin o.reg_write = 1'b1; o.reg_dst = 2'd2; o.m2r = 2'd2; end
      scr.push_back(o);
    end
    return scr.size();
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    logic [5:0] opc, fn;
    case ($urandom_range(0, 13))
      0:  return {6'h00, r[25:6], 6'h21};
      1:  return {6'h00, r[25:6], 6'h23};
      2:  return {6'h00, r[25:6], 6'h2A};
      3:  return {6'h00, r[25:6], 6'h00};
      4:  return {6'h00, r[25:6], 6'h08};
      5:  return {6'h0D, r[25:0]};
      6:  return {6'h0F, r[25:0]};
      7:  return {6'h23, r[25:0]};
      8:  return {6'h2B, r[25:0]};
      9:  return {6'h04, r[25:0]};
      10: return {6'h02, r[25:0]};
      11: return {6'h03, r[25:0]};
      12: begin
        do opc = 6'($urandom_range(0, 63));
        while (opc inside {6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03});
        return {opc, r[25:0]};
      end
      default: begin
        do fn = 6'($urandom_range(0, 63));
        while (fn inside {6'h21, 6'h23, 6'h2A, 6'h00, 6'h08});
        return {6'h00, r[25:6], fn};
      end
    endcase
  endfunction

  task automatic do_instr(int k, int lat, logic [31:0] w, logic zz);
    int n = build(w, zz, lat);
    foreach (scr[i]) push(k, scr[i]);
    repeat (lat) @(posedge clk);
    #1;
    ins[k] = w;
    z[k]   = zz;
    repeat (n - lat) @(posedge clk);
    #1;
  endtask

  task automatic run_dut(int k);
    int lat = k + 1;
    obs_t o;
    logic [31:0] dir [15] = '{32'h00221821, 32'h8C080004, 32'hAC080004, 32'h10220002,
                              32'h10220002, 32'h0C000010, 32'h03E00008, 32'hFC000000,
                              32'h00000000, 32'h3428ABCD, 32'h3C081234, 32'h00221823,
                              32'h0022182A, 32'h00021880, 32'h08000040};
    logic dz [15] = '{0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0, 1, 0, 1, 0};
    rst[k] = 1'b1; ins[k] = '0; z[k] = 1'b0;
    @(posedge clk);
    #1;
    push(k, obs_t'('0));
    @(posedge clk);
    #1;
    rst[k] = 1'b0;
    for (int i = 0; i < 15; i++) do_instr(k, lat, dir[i], dz[i]);
    if (lat == 3) begin
      // Reset lands in the 2nd MEM_WR cycle of a sw; the strobe must never appear.
      void'(build(32'hAC080004, 1'b0, lat));
      for (int i = 0; i < 6; i++) push(k, scr[i]);
      repeat (lat) @(posedge clk);
      #1;
      ins[k] = 32'hAC080004;
      repeat (3) @(posedge clk);
      #1;
      rst[k] = 1'b1;
      o = '0; o.st = 4'd6;
      push(k, o);
      @(posedge clk);
      #1;
      rst[k] = 1'b0;
      do_instr(k, lat, 32'h00221821, 1'b0);
    end
    repeat (50) do_instr(k, lat, rand_instr(), 1'($urandom_range(0, 1)));
  endtask

  always @(negedge clk) begin
    obs_t gv, ev;
    bit have;
    for (int k = 0; k < 3; k++) begin
      have = 1'b0;
      ev = '0;
      case (k)
        0:       if (q0.size() > 0) begin ev = q0.pop_front(); have = 1'b1; end
        1:       if (q1.size() > 0) begin ev = q1.pop_front(); have = 1'b1; end
        default: if (q2.size() > 0) begin ev = q2.pop_front(); have = 1'b1; end
      endcase
      if (have) begin
        gv = get_obs(k);
        n_cmp++;
        if (gv !== ev) begin
          n_bad++;
          $display("FAIL outputs lat%0d t=%0t: got st=%0d vec=%h, want st=%0d vec=%h",
                   k + 1, $time, gv.st, gv, ev.st, ev);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    fork
      run_dut(0);
      run_dut(1);
      run_dut(2);
    join
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unconsumed expectations, want 0",
               q0.size() + q1.size() + q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
